// File: rtl/hash_pp_gen.sv
// Two-stage partial-product generator for the Pigasus multiplicative hash (window x HASH_B).
// Masked 8x16 products are built only when HASH_PP_MSK_EN is defined; otherwise msk_* read 0.
module hash_pp_gen #(
  parameter logic [63:0] HASH_B = 64'h0b4e0ef37bc32127
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] in_data,
  input  logic        in_sign,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        out_sign,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] a0b0, a0b1, a0b2, a0b3, a1b0, a1b1, a1b2, a2b0, a2b1, a3b0,
  output logic [31:0] a0b0_1sc, a0b1_1sc, a0b2_1sc, a0b3_1sc, a1b0_1sc,
  output logic [31:0] a1b1_1sc, a1b2_1sc, a2b0_1sc, a2b1_1sc, a3b0_1sc,
  output logic [23:0] msk_a0b0, msk_a0b1, msk_a0b2, msk_a0b3, msk_a1b0,
  output logic [23:0] msk_a1b1, msk_a1b2, msk_a2b0, msk_a2b1,
  output logic [23:0] msk_a0b0_1sc, msk_a0b1_1sc, msk_a0b2_1sc, msk_a0b3_1sc, msk_a1b0_1sc,
  output logic [23:0] msk_a1b1_1sc, msk_a1b2_1sc, msk_a2b0_1sc, msk_a2b1_1sc
);

  localparam int NP = 10;
  localparam int NM = 9;
  // Pair k -> (i,j) in port order; the masked set is the first NM pairs (no a3 term).
  localparam int PI [NP] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3};
  localparam int PJ [NP] = '{0, 1, 2, 3, 0, 1, 2, 0, 1, 0};
  localparam logic [3:0][15:0] B_S = HASH_B;

  logic             w_adv;
  logic [63:0]      r_s1_data;
  logic             r_s1_sign;
  logic             r_s1_valid;
  logic             r_out_valid;
  logic             r_out_sign;
  logic [3:0][15:0] w_a;
  logic [3:0][15:0] w_a_n;
  logic [31:0]      r_pp     [NP];
  logic [31:0]      r_pp_1sc [NP];

  assign w_adv     = !r_out_valid || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_out_valid;
  assign out_sign  = r_out_sign;

  assign w_a   = r_s1_data;
  assign w_a_n = ~r_s1_data;

  // NOTE: all state uses non-blocking assignments so both stages advance on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sign  <= 1'b0;
    end else if (w_adv) begin
      r_s1_valid  <= in_valid;
      r_out_valid <= r_s1_valid;
      r_out_sign  <= r_s1_sign;
    end
  end

  // NOTE: the S1 data register is left unreset; r_s1_valid alone qualifies its contents.
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_s1_data <= in_data;
      r_s1_sign <= in_sign;
    end
  end

  for (genvar k = 0; k < NP; k++) begin : g_pp
    always_ff @(posedge clk) begin
      if (rst) begin
        r_pp[k]     <= '0;
        r_pp_1sc[k] <= '0;
      end else if (w_adv) begin
        r_pp[k]     <= 32'(w_a[PI[k]])   * 32'(B_S[PJ[k]]);
        r_pp_1sc[k] <= 32'(w_a_n[PI[k]]) * 32'(B_S[PJ[k]]);
      end
    end
  end

`ifdef HASH_PP_MSK_EN
  logic [23:0] r_msk     [NM];
  logic [23:0] r_msk_1sc [NM];

  for (genvar k = 0; k < NM; k++) begin : g_msk
    always_ff @(posedge clk) begin
      if (rst) begin
        r_msk[k]     <= '0;
        r_msk_1sc[k] <= '0;
      end else if (w_adv) begin
        r_msk[k]     <= 24'(w_a[PI[k]][15:8])   * 24'(B_S[PJ[k]]);
        r_msk_1sc[k] <= 24'(w_a_n[PI[k]][15:8]) * 24'(B_S[PJ[k]]);
      end
    end
  end

  assign msk_a0b0     = r_msk[0];
  assign msk_a0b1     = r_msk[1];
  assign msk_a0b2     = r_msk[2];
  assign msk_a0b3     = r_msk[3];
  assign msk_a1b0     = r_msk[4];
  assign msk_a1b1     = r_msk[5];
  assign msk_a1b2     = r_msk[6];
  assign msk_a2b0     = r_msk[7];
  assign msk_a2b1     = r_msk[8];
  assign msk_a0b0_1sc = r_msk_1sc[0];
  assign msk_a0b1_1sc = r_msk_1sc[1];
  assign msk_a0b2_1sc = r_msk_1sc[2];
  assign msk_a0b3_1sc = r_msk_1sc[3];
  assign msk_a1b0_1sc = r_msk_1sc[4];
  assign msk_a1b1_1sc = r_msk_1sc[5];
  assign msk_a1b2_1sc = r_msk_1sc[6];
  assign msk_a2b0_1sc = r_msk_1sc[7];
  assign msk_a2b1_1sc = r_msk_1sc[8];
`else
  assign msk_a0b0     = '0;
  assign msk_a0b1     = '0;
  assign msk_a0b2     = '0;
  assign msk_a0b3     = '0;
  assign msk_a1b0     = '0;
  assign msk_a1b1     = '0;
  assign msk_a1b2     = '0;
  assign msk_a2b0     = '0;
  assign msk_a2b1     = '0;
  assign msk_a0b0_1sc = '0;
  assign msk_a0b1_1sc = '0;
  assign msk_a0b2_1sc = '0;
  assign msk_a0b3_1sc = '0;
  assign msk_a1b0_1sc = '0;
  assign msk_a1b1_1sc = '0;
  assign msk_a1b2_1sc = '0;
  assign msk_a2b0_1sc = '0;
  assign msk_a2b1_1sc = '0;
`endif

  assign a0b0     = r_pp[0];
  assign a0b1     = r_pp[1];
  assign a0b2     = r_pp[2];
  assign a0b3     = r_pp[3];
  assign a1b0     = r_pp[4];
  assign a1b1     = r_pp[5];
  assign a1b2     = r_pp[6];
  assign a2b0     = r_pp[7];
  assign a2b1     = r_pp[8];
  assign a3b0     = r_pp[9];
  assign a0b0_1sc = r_pp_1sc[0];
  assign a0b1_1sc = r_pp_1sc[1];
  assign a0b2_1sc = r_pp_1sc[2];
  assign a0b3_1sc = r_pp_1sc[3];
  assign a1b0_1sc = r_pp_1sc[4];
  assign a1b1_1sc = r_pp_1sc[5];
  assign a1b2_1sc = r_pp_1sc[6];
  assign a2b0_1sc = r_pp_1sc[7];
  assign a2b1_1sc = r_pp_1sc[8];
  assign a3b0_1sc = r_pp_1sc[9];

endmodule

// File: tb/tb_hash_pp_gen.sv
// Self-checking bench for hash_pp_gen: directed table, latency/backpressure/reset sequences,
// and a randomized stream scored against an arithmetic model of the partial products.
module tb_hash_pp_gen;

  localparam logic [63:0] HB = 64'h0b4e0ef37bc32127;
`ifdef HASH_PP_MSK_EN
  localparam bit MSK_EN = 1'b1;
`else
  localparam bit MSK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] in_data;
  logic        in_sign;
  logic        in_valid;
  logic        in_ready;
  logic        out_sign;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] a0b0, a0b1, a0b2, a0b3, a1b0, a1b1, a1b2, a2b0, a2b1, a3b0;
  logic [31:0] a0b0_1sc, a0b1_1sc, a0b2_1sc, a0b3_1sc, a1b0_1sc;
  logic [31:0] a1b1_1sc, a1b2_1sc, a2b0_1sc, a2b1_1sc, a3b0_1sc;
  logic [23:0] msk_a0b0, msk_a0b1, msk_a0b2, msk_a0b3, msk_a1b0, msk_a1b1, msk_a1b2, msk_a2b0, msk_a2b1;
  logic [23:0] msk_a0b0_1sc, msk_a0b1_1sc, msk_a0b2_1sc, msk_a0b3_1sc, msk_a1b0_1sc;
  logic [23:0] msk_a1b1_1sc, msk_a1b2_1sc, msk_a2b0_1sc, msk_a2b1_1sc;

  always #5 clk = ~clk;

  hash_pp_gen #(.HASH_B(HB)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sign(in_sign), .in_valid(in_valid),
    .in_ready(in_ready), .out_sign(out_sign), .out_valid(out_valid), .out_ready(out_ready),
    .a0b0(a0b0), .a0b1(a0b1), .a0b2(a0b2), .a0b3(a0b3), .a1b0(a1b0),
    .a1b1(a1b1), .a1b2(a1b2), .a2b0(a2b0), .a2b1(a2b1), .a3b0(a3b0),
    .a0b0_1sc(a0b0_1sc), .a0b1_1sc(a0b1_1sc), .a0b2_1sc(a0b2_1sc), .a0b3_1sc(a0b3_1sc),
    .a1b0_1sc(a1b0_1sc), .a1b1_1sc(a1b1_1sc), .a1b2_1sc(a1b2_1sc), .a2b0_1sc(a2b0_1sc),
    .a2b1_1sc(a2b1_1sc), .a3b0_1sc(a3b0_1sc),
    .msk_a0b0(msk_a0b0), .msk_a0b1(msk_a0b1), .msk_a0b2(msk_a0b2), .msk_a0b3(msk_a0b3),
    .msk_a1b0(msk_a1b0), .msk_a1b1(msk_a1b1), .msk_a1b2(msk_a1b2), .msk_a2b0(msk_a2b0),
    .msk_a2b1(msk_a2b1),
    .msk_a0b0_1sc(msk_a0b0_1sc), .msk_a0b1_1sc(msk_a0b1_1sc), .msk_a0b2_1sc(msk_a0b2_1sc),
    .msk_a0b3_1sc(msk_a0b3_1sc), .msk_a1b0_1sc(msk_a1b0_1sc), .msk_a1b1_1sc(msk_a1b1_1sc),
    .msk_a1b2_1sc(msk_a1b2_1sc), .msk_a2b0_1sc(msk_a2b0_1sc), .msk_a2b1_1sc(msk_a2b1_1sc)
  );

  typedef struct packed {
    logic             sign;
    logic [9:0][31:0] pp;
    logic [9:0][31:0] pp1;
    logic [8:0][23:0] m;
    logic [8:0][23:0] m1;
  } beat_t;

  typedef struct {
    logic [63:0] d;
    logic        s;
    logic [31:0] a0b0, a0b3, a0b0_1sc, a1b0_1sc, a3b0;
    logic [23:0] m00, m00_1sc;
  } vec_t;

  beat_t act;
  always_comb begin
    act.sign = out_sign;
    act.pp   = {a3b0, a2b1, a2b0, a1b2, a1b1, a1b0, a0b3, a0b2, a0b1, a0b0};
    act.pp1  = {a3b0_1sc, a2b1_1sc, a2b0_1sc, a1b2_1sc, a1b1_1sc, a1b0_1sc,
                a0b3_1sc, a0b2_1sc, a0b1_1sc, a0b0_1sc};
    act.m    = {msk_a2b1, msk_a2b0, msk_a1b2, msk_a1b1, msk_a1b0,
                msk_a0b3, msk_a0b2, msk_a0b1, msk_a0b0};
    act.m1   = {msk_a2b1_1sc, msk_a2b0_1sc, msk_a1b2_1sc, msk_a1b1_1sc, msk_a1b0_1sc,
                msk_a0b3_1sc, msk_a0b2_1sc, msk_a0b1_1sc, msk_a0b0_1sc};
  end

  int    n_vec = 0;
  int    n_err = 0;
  beat_t exp_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: slice window and constant into 16-bit digits and multiply with plain integers.
  function automatic beat_t model(input logic [63:0] d, input logic s);
    beat_t r;
    int k;
    longint unsigned ai, an, bj;
    r = '0;
    r.sign = s;
    k = 0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4 - i; j++) begin
        ai = (d >> (16 * i)) & 64'hffff;
        an = ai ^ 64'hffff;
        bj = (HB >> (16 * j)) & 64'hffff;
        r.pp[k]  = 32'(ai * bj);
        r.pp1[k] = 32'(an * bj);
        if (i < 3 && MSK_EN) begin
          r.m[k]  = 24'((ai >> 8) * bj);
          r.m1[k] = 24'((an >> 8) * bj);
        end
        k++;
      end
    end
    return r;
  endfunction

  task automatic compare_beat(input string tag, input beat_t got, input beat_t exp);
    check($sformatf("%s sign", tag), 64'(got.sign), 64'(exp.sign));
    for (int k = 0; k < 10; k++) begin
      check($sformatf("%s pp[%0d]", tag, k), 64'(got.pp[k]), 64'(exp.pp[k]));
      check($sformatf("%s pp1sc[%0d]", tag, k), 64'(got.pp1[k]), 64'(exp.pp1[k]));
    end
    for (int k = 0; k < 9; k++) begin
      check($sformatf("%s msk[%0d]", tag, k), 64'(got.m[k]), 64'(exp.m[k]));
      check($sformatf("%s msk1sc[%0d]", tag, k), 64'(got.m1[k]), 64'(exp.m1[k]));
    end
  endtask

  // Scoreboard: score every output handshake, then record every input handshake.
  always @(negedge clk) begin
    beat_t e;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected beat: out_valid=1 with no beat outstanding (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        compare_beat("stream", act, e);
      end
    end
    if (rst === 1'b1) exp_q.delete();
    else if (in_valid === 1'b1 && in_ready === 1'b1) exp_q.push_back(model(in_data, in_sign));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    for (int t = 0; t < 40 && exp_q.size() != 0; t++) step();
    check($sformatf("%s beats left", tag), 64'(exp_q.size()), 64'd0);
  endtask

  // One beat through an idle pipe: checks acceptance and the 2-edge latency.
  task automatic single_beat(input string tag, input logic [63:0] d, input logic s);
    in_data  = d;
    in_sign  = s;
    in_valid = 1'b1;
    check($sformatf("%s in_ready", tag), 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    check($sformatf("%s valid@+1", tag), 64'(out_valid), 64'd0);
    step();
    check($sformatf("%s valid@+2", tag), 64'(out_valid), 64'd1);
    compare_beat(tag, act, model(d, s));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  vt[4];
    beat_t snap, prev;
    logic  prev_stall;
    int    run, max_run;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sign = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_sign", 64'(out_sign), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset products zero", 64'(act == '0), 64'd1);
    step();

    vt[0] = '{64'h1, 1'b0, 32'h2127, 32'h0b4e, 32'h2126BDB2, 32'h2126DED9, 32'h0,
              24'h0, MSK_EN ? 24'h2105D9 : 24'h0};
    vt[1] = '{64'hff00, 1'b1, 32'h2105D900, 32'h0B42B200, 32'h002105D9, 32'h2126DED9, 32'h0,
              MSK_EN ? 24'h2105D9 : 24'h0, 24'h0};
    vt[2] = '{64'hffff_ffff_ffff_ffff, 1'b1, 32'h2126DED9, 32'h0B4DF4B2, 32'h0, 32'h0, 32'h2126DED9,
              MSK_EN ? 24'h2105D9 : 24'h0, 24'h0};
    vt[3] = '{64'h0, 1'b0, 32'h0, 32'h0, 32'h2126DED9, 32'h2126DED9, 32'h0,
              24'h0, MSK_EN ? 24'h2105D9 : 24'h0};
    for (int v = 0; v < 4; v++) begin
      single_beat($sformatf("vec%0d", v), vt[v].d, vt[v].s);
      check($sformatf("vec%0d a0b0", v), 64'(a0b0), 64'(vt[v].a0b0));
      check($sformatf("vec%0d a0b3", v), 64'(a0b3), 64'(vt[v].a0b3));
      check($sformatf("vec%0d a0b0_1sc", v), 64'(a0b0_1sc), 64'(vt[v].a0b0_1sc));
      check($sformatf("vec%0d a1b0_1sc", v), 64'(a1b0_1sc), 64'(vt[v].a1b0_1sc));
      check($sformatf("vec%0d a3b0", v), 64'(a3b0), 64'(vt[v].a3b0));
      check($sformatf("vec%0d msk_a0b0", v), 64'(msk_a0b0), 64'(vt[v].m00));
      check($sformatf("vec%0d msk_a0b0_1sc", v), 64'(msk_a0b0_1sc), 64'(vt[v].m00_1sc));
      check($sformatf("vec%0d out_sign", v), 64'(out_sign), 64'(vt[v].s));
      step();
    end
    drain("directed");

    // 16 back-to-back beats must give one unbroken run of 16 valid cycles.
    out_ready = 1'b1;
    run = 0;
    max_run = 0;
    for (int t = 0; t < 22; t++) begin
      in_valid = (t < 16);
      in_data  = {$urandom, $urandom};
      in_sign  = 1'($urandom);
      step();
      run = out_valid ? run + 1 : 0;
      if (run > max_run) max_run = run;
    end
    in_valid = 1'b0;
    check("stream valid run", 64'(max_run), 64'd16);
    drain("stream");

    // Backpressure: fill both stages, hold a third beat at the input, stall 5 cycles.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h1111_2222_3333_4444; in_sign = 1'b1;
    step();
    in_data   = 64'h5555_6666_7777_8888; in_sign = 1'b0;
    step();
    in_data   = 64'h9999_aaaa_bbbb_cccc; in_sign = 1'b1;
    snap = act;
    for (int t = 0; t < 5; t++) begin
      step();
      check($sformatf("stall%0d in_ready", t), 64'(in_ready), 64'd0);
      check($sformatf("stall%0d out_valid", t), 64'(out_valid), 64'd1);
      check($sformatf("stall%0d outputs stable", t), 64'(act == snap), 64'd1);
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    drain("backpressure");

    // Reset with two beats in flight discards them.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 64'hdead_beef_0123_4567; in_sign = 1'b1;
    step();
    in_data   = 64'hcafe_f00d_89ab_cdef; in_sign = 1'b0;
    step();
    in_valid  = 1'b0;
    rst       = 1'b1;
    step();
    rst = 1'b0;
    check("midrst out_valid", 64'(out_valid), 64'd0);
    check("midrst products zero", 64'(act == '0), 64'd1);
    check("midrst in_ready", 64'(in_ready), 64'd1);
    step();
    check("midrst no late beat", 64'(out_valid), 64'd0);
    single_beat("postrst", 64'h0123_4567_89ab_cdef, 1'b1);
    step();
    drain("postrst");

    // Random valid/ready traffic; outputs must hold whenever the previous cycle stalled.
    prev_stall = 1'b0;
    prev = act;
    for (int t = 0; t < 400; t++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = {$urandom, $urandom};
      in_sign   = 1'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      prev_stall = out_valid && !out_ready;
      prev = act;
      step();
      if (prev_stall) begin
        check($sformatf("rand%0d held valid", t), 64'(out_valid), 64'd1);
        check($sformatf("rand%0d held data", t), 64'(act == prev), 64'd1);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain("random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hash_pp_gen.md
# hash_pp_gen

Pipelined partial-product generator for the Pigasus string-matching multiplicative hash. It takes a 64-bit input window and a sign flag and splits the window into 16-bit slices. It produces every 16x16 and 8x16 partial product, in plain, one's-complement and low-byte-masked forms, against the fixed hash constant. It sits directly upstream of the hash accumulation/truncation stage and drives that stage's partial-product inputs, with a valid/ready handshake added on both sides.

## Interface

**Parameters**
- `HASH_B`, default 64'h0b4e0ef37bc32127: multiplier constant; must match the hash accumulator constant. Slices: b0=[15:0], b1=[31:16], b2=[47:32], b3=[63:48].

**Ports**
- `clk`, input, 1: sole clock.
- `rst`, input, 1: synchronous, active-high reset.
- `in_data`, input, 64: window `a`. Slices: a0=[15:0], a1=[31:16], a2=[47:32], a3=[63:48].
- `in_sign`, input, 1: sign flag; carried alongside the data.
- `in_valid`, input, 1: input beat valid.
- `in_ready`, output, 1: block can accept a beat.
- `out_sign`, output, 1: registered copy of the beat's sign.
- `out_valid`, output, 1: output beat valid.
- `out_ready`, input, 1: downstream accepts the beat.
- `aibj`, output, 32 each, for (i,j) with i+j≤3 (10 ports: a0b0..a0b3, a1b0..a1b2, a2b0, a2b1, a3b0): ai*bj.
- `aibj_1sc`, output, 32 each, same 10 pairs: (~ai)*bj.
- `msk_aibj`, output, 24 each, for i+j≤3 with i≤2 (9 ports): ai[15:8]*bj.
- `msk_aibj_1sc`, output, 24 each, same 9 pairs: (~ai)[15:8]*bj.

## Operation

- **Product widths:**
  - 16x16 products are unsigned and full width (32 bits), with no truncation.
  - 8x16 products are unsigned, 24 bits.
  - There are no a3 masked products.
- **One's complement:** the one's-complement slice is the bitwise inverse of the 16-bit input slice. There is no +1 here; the downstream stage adds the correction.
- **Sign handling:** sign is not used arithmetically. It is delayed identically to the data.
- **Pipeline structure:** two register stages.
  - S1 captures `in_data`/`in_sign`.
  - S2 holds the products computed from S1.
- **Advance condition:** `adv = !out_valid || out_ready`.
  - `in_ready = adv`, computed combinationally from output state only. It does not depend on `in_valid`.
  - When `adv` is high:
    - S1 loads the input and `s1_valid <= in_valid`.
    - S2 loads the products from S1 and `out_valid <= s1_valid`.
  - When `adv` is low, all stage registers hold.
- **Output stability:** all outputs are registered. Data and sign stay stable while `out_valid && !out_ready`.
- **Bubbles:** bubbles (invalid slots) propagate and are squeezed out while `out_valid` is 0.
- **Reset:**
  - `s1_valid`, `out_valid` and `out_sign` are set to 0.
  - All product outputs are set to 0.
  - `in_ready` reads 1 in the cycle after reset is released.
- **Reset mid-operation:** any beats in flight are discarded and no partial beat is emitted.
- **Accept and emit in the same cycle:** an input accept and an output handshake may occur in the same cycle. Throughput is then sustained at 1 beat/cycle.

## Timing

- **Latency:** a beat accepted at edge N (`in_valid && in_ready`) appears with `out_valid=1` after edge N+2 when unstalled.
- **Throughput:** 1 beat/cycle while `out_ready=1`.
- **Stall:** each cycle of `out_ready=0` with `out_valid=1` adds one cycle of latency to every beat in flight. No beat is dropped or duplicated.
- **Combined latency:** this block plus the accumulator gives 2 + 6 = 8 cycles from window to hash.
- **Multiplier mapping:** each product register should map to one DSP multiplier with an output register. Stage S1 is the DSP input register.

## Configuration

- **Macro:** `HASH_PP_MSK_EN`.
- **Defined:** all 18 masked outputs are computed and pipelined as above.
- **Undefined:**
  - The masked multipliers and their registers are removed.
  - All `msk_*` outputs are tied to 24'd0.
  - This build may only be paired with downstream configurations whose mask leaves an even number of low bytes masked.
  - Handshake and latency are unchanged.

## Test plan

- **Unit input:** `in_data`=64'h1, sign=0, `out_ready`=1 → after 2 cycles:
  - a0b0=32'h2127, a0b1=32'h7bc3, a0b2=32'h0ef3, a0b3=32'h0b4e.
  - a0b0_1sc=32'h2126BDB2, a1b0_1sc=32'h2126DED9.
  - All other plain products are 0; msk_a0b0=0.
- **Masked products:** `in_data`=64'hff00, sign=1 → msk_a0b0=24'h2105D9, msk_a0b0_1sc=0, a0b0=32'h2105D900, `out_sign`=1.
- **Back-to-back stream:** 16 random beats, `out_ready`=1 → 16 consecutive `out_valid` cycles. Outputs match the reference model in order.
- **Backpressure:** with 3 beats in flight, hold `out_ready`=0 for 5 cycles → outputs stable throughout and `in_ready`=0. Release → remaining beats emitted in order with no loss or duplication.
- **Reset mid-stream:** assert `rst` for 1 cycle with 2 beats in flight →
  - Next cycle: `out_valid`=0 and all products 0.
  - `in_ready`=1.
  - A new beat then emerges 2 cycles after it is accepted.
- **`HASH_PP_MSK_EN` undefined:** repeat the masked-products scenario → every `msk_*` output is 0; plain and one's-complement products are unchanged.
